// File: rtl/egen_row_scheduler_if.sv
// egen_row_scheduler_if
//   Bundles the control, memory-strobe and status signals of the row
//   scheduler.
//   master : the scheduler side. It receives start/max_iter/mem_busy/syn_zero
//            and drives the read/write strobes and status.
//   slave  : the decoder-control side, which is the mirror image.
//   Ports carried:
//     start, max_iter, mem_busy, syn_zero       (to scheduler)
//     rd_en, rd_addr, wr_en, wr_addr, iter_cnt,
//     busy, done, early_exit                    (from scheduler)
interface egen_row_scheduler_if #(
  parameter int ROWBITS  = 4,
  parameter int ITERBITS = 4
);
  logic                start;
  logic [ITERBITS-1:0] max_iter;
  logic                mem_busy;
  logic                syn_zero;
  logic                rd_en;
  logic [ROWBITS-1:0]  rd_addr;
  logic                wr_en;
  logic [ROWBITS-1:0]  wr_addr;
  logic [ITERBITS-1:0] iter_cnt;
  logic                busy;
  logic                done;
  logic                early_exit;

  modport master (
    input  start, max_iter, mem_busy, syn_zero,
    output rd_en, rd_addr, wr_en, wr_addr, iter_cnt, busy, done, early_exit
  );

  modport slave (
    output start, max_iter, mem_busy, syn_zero,
    input  rd_en, rd_addr, wr_en, wr_addr, iter_cnt, busy, done, early_exit
  );
endinterface

// File: rtl/egen_row_scheduler.sv
// egen_row_scheduler
//   Steps check-node rows through the compressed-extrinsic generator.
//   - Issues one LLR/sign memory row read per free cycle.
//   - Counts rows and iterations.
//   - Carries a {valid,row} tag down a delay line matching the read plus
//     generator latency, so each Ecomp word is written to its own row.
//   Ports:
//     clk, rst : system clock and asynchronous active-high reset
//     bus      : egen_row_scheduler_if.master
//                (start/max_iter/mem_busy/syn_zero in;
//                 rd/wr strobes, iter_cnt, busy, done, early_exit out)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; counters and early_exit hold last result
//   RUN   | issuing rows; a mem_busy cycle inserts a bubble
//   DRAIN | no new reads; waiting for in-flight tags to reach the E-memory
//   DONE  | one-cycle done pulse, then back to IDLE
module egen_row_scheduler #(
  parameter int NROWS    = 16,
  parameter int ROWBITS  = 4,
  parameter int ITERBITS = 4,
  parameter int RD_LAT   = 1,
  parameter int EGEN_LAT = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  egen_row_scheduler_if.master        bus
);

  localparam int                 DEPTH    = RD_LAT + EGEN_LAT;
  localparam logic [ROWBITS-1:0] LAST_ROW = ROWBITS'(NROWS - 1);
  localparam logic [ROWBITS-1:0] ROW_ONE  = ROWBITS'(1);
  localparam logic [ITERBITS-1:0] ITER_ONE = ITERBITS'(1);
  localparam logic [ITERBITS:0]  ITER_ONE_X = (ITERBITS + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                      state_q,      state_d;
  logic [ROWBITS-1:0]          row_cnt_q,    row_cnt_d;
  logic [ITERBITS-1:0]         iter_cnt_q,   iter_cnt_d;
  logic [ITERBITS-1:0]         lim_q,        lim_d;
  logic                        early_exit_q, early_exit_d;
  logic [DEPTH-1:0]            pipe_vld_q,   pipe_vld_d;
  logic [DEPTH-1:0][ROWBITS-1:0] pipe_row_q, pipe_row_d;

  logic issue;
  logic wrap;
  logic last_iter;

  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    iter_cnt_d   = iter_cnt_q;
    lim_d        = lim_q;
    early_exit_d = early_exit_q;
    issue        = 1'b0;
    wrap         = 1'b0;
    // One extra bit, so a limit of 2^ITERBITS-1 is still reachable.
    last_iter    = (({1'b0, iter_cnt_q} + ITER_ONE_X) == {1'b0, lim_q});

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          lim_d        = (bus.max_iter == '0) ? ITER_ONE : bus.max_iter;
          row_cnt_d    = '0;
          iter_cnt_d   = '0;
          early_exit_d = 1'b0;
          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        issue = !bus.mem_busy;
        // A busy cycle blocks the wrap; it happens on the next issue.
        wrap  = issue && (row_cnt_q == LAST_ROW);
        if (issue) begin
          row_cnt_d = wrap ? '0 : row_cnt_q + ROW_ONE;
        end
        if (wrap) begin
          iter_cnt_d = iter_cnt_q + ITER_ONE;
          if (last_iter) begin
            state_d = S_DRAIN;
          end else if (bus.syn_zero) begin
            state_d      = S_DRAIN;
            early_exit_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // The last stage of the pipe is wr_en, so this also covers wr_en==0.
        if (pipe_vld_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The tag pipe shifts every cycle; a non-issue cycle enters as a bubble.
    pipe_vld_d = {pipe_vld_q[DEPTH-2:0], issue};
    pipe_row_d = {pipe_row_q[DEPTH-2:0], row_cnt_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_cnt_q    <= '0;
      iter_cnt_q   <= '0;
      lim_q        <= '0;
      early_exit_q <= 1'b0;
      pipe_vld_q   <= '0;
      pipe_row_q   <= '0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      iter_cnt_q   <= iter_cnt_d;
      lim_q        <= lim_d;
      early_exit_q <= early_exit_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_row_q   <= pipe_row_d;
    end
  end

  assign bus.rd_en      = issue;
  assign bus.rd_addr    = row_cnt_q;
  assign bus.wr_en      = pipe_vld_q[DEPTH-1];
  assign bus.wr_addr    = pipe_row_q[DEPTH-1];
  assign bus.iter_cnt   = iter_cnt_q;
  assign bus.busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done       = (state_q == S_DONE);
  assign bus.early_exit = early_exit_q;

endmodule
